// File: rtl/wb_arbiter2.sv
// wb_arbiter2: two-master, one-slave arbiter for the pipelined Wishbone bus.
//
// Master A (core data port) and master B (debug loader / DMA) share one slave
// port. Ownership is granted round-robin and held for the owner's whole cyc
// window. The arbiter counts accepted-but-unanswered requests, stalls the owner
// at MAX_OUTSTANDING, and aborts the bus with an error if the slave stays
// silent for TIMEOUT_CYCLES while requests are pending.
//
// Ports:
//   i_clk, i_reset                 clock, asynchronous active-high reset
//   a_cyc/a_stb/a_we/a_addr/a_mosi/a_sel   master A request
//   a_ack/a_stall/a_err/a_miso              master A response
//   b_*                            master B, same set as master A
//   s_cyc/s_stb/s_we/s_addr/s_mosi/s_sel   slave-side request
//   s_ack/s_stall/s_err/s_miso              slave response
//   o_owner                        0 none, 1 A, 2 B (ABORT keeps the aborted owner)
//   o_timeout                      one-cycle pulse on the first ABORT cycle
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | no owner; arbitrate among raised cyc lines
// OWN_A  | master A owns the bus, request/response muxed to A
// OWN_B  | master B owns the bus, request/response muxed to B
// ABORT  | slave timed out; bus dropped until the owner releases cyc

module wb_arbiter2 #(
    parameter int MAX_OUTSTANDING = 4,
    parameter int TIMEOUT_CYCLES  = 1024,
    parameter int CNT_W           = 11
) (
    input  logic        i_clk,
    input  logic        i_reset,

    input  logic        a_cyc,
    input  logic        a_stb,
    input  logic        a_we,
    input  logic [29:0] a_addr,
    input  logic [31:0] a_mosi,
    input  logic [3:0]  a_sel,
    output logic        a_ack,
    output logic        a_stall,
    output logic        a_err,
    output logic [31:0] a_miso,

    input  logic        b_cyc,
    input  logic        b_stb,
    input  logic        b_we,
    input  logic [29:0] b_addr,
    input  logic [31:0] b_mosi,
    input  logic [3:0]  b_sel,
    output logic        b_ack,
    output logic        b_stall,
    output logic        b_err,
    output logic [31:0] b_miso,

    output logic        s_cyc,
    output logic        s_stb,
    output logic        s_we,
    output logic [29:0] s_addr,
    output logic [31:0] s_mosi,
    output logic [3:0]  s_sel,
    input  logic        s_ack,
    input  logic        s_stall,
    input  logic        s_err,
    input  logic [31:0] s_miso,

    output logic [1:0]  o_owner,
    output logic        o_timeout
);

    localparam int               OUT_W    = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [OUT_W-1:0] OUT_MAX  = OUT_W'(MAX_OUTSTANDING);
    localparam logic [CNT_W-1:0] TMR_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, OWN_A, OWN_B, ABORT} state_t;

    state_t           state;
    logic             last_b;
    logic [OUT_W-1:0] outstanding;
    logic [CNT_W-1:0] timer;

    logic             sel_a, sel_b;
    logic             at_limit, have_out;
    logic             accept, resp, quiet, fire;
    logic             own_cyc, other_cyc;
    logic [CNT_W-1:0] timer_inc;

    assign sel_a    = (state == OWN_A);
    assign sel_b    = (state == OWN_B);
    assign at_limit = (outstanding == OUT_MAX);
    assign have_out = (outstanding != '0);

    always_comb begin
        s_cyc  = 1'b0;
        s_stb  = 1'b0;
        s_we   = 1'b0;
        s_addr = '0;
        s_mosi = '0;
        s_sel  = '0;
        if (sel_a) begin
            s_cyc  = a_cyc;
            s_stb  = a_stb & ~at_limit;
            s_we   = a_we;
            s_addr = a_addr;
            s_mosi = a_mosi;
            s_sel  = a_sel;
        end else if (sel_b) begin
            s_cyc  = b_cyc;
            s_stb  = b_stb & ~at_limit;
            s_we   = b_we;
            s_addr = b_addr;
            s_mosi = b_mosi;
            s_sel  = b_sel;
        end
    end

    // Responses only count while something is pending; a stray ack is dropped.
    assign a_stall = ~sel_a | s_stall | at_limit;
    assign b_stall = ~sel_b | s_stall | at_limit;
    assign a_ack   = sel_a & s_ack & have_out;
    assign b_ack   = sel_b & s_ack & have_out;
    assign a_err   = (sel_a & s_err & have_out) |
                     ((state == ABORT) & (o_owner == 2'd1) & o_timeout);
    assign b_err   = (sel_b & s_err & have_out) |
                     ((state == ABORT) & (o_owner == 2'd2) & o_timeout);
    assign a_miso  = sel_a ? s_miso : '0;
    assign b_miso  = sel_b ? s_miso : '0;

    assign accept    = s_stb & ~s_stall;
    assign resp      = (s_ack | s_err) & have_out;
    assign quiet     = have_out & ~s_ack & ~s_err & ~accept;
    assign timer_inc = timer + CNT_W'(1);
    // Abort on the edge where the timer would step onto TIMEOUT_CYCLES-1, so
    // the error appears TIMEOUT_CYCLES cycles after the last accepted request.
    assign fire      = (sel_a | sel_b) & quiet & (timer_inc == TMR_LAST);

    assign own_cyc   = o_owner[1] ? b_cyc : a_cyc;
    assign other_cyc = o_owner[1] ? a_cyc : b_cyc;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state       <= IDLE;
            last_b      <= 1'b1;
            outstanding <= '0;
            timer       <= '0;
            o_owner     <= 2'd0;
            o_timeout   <= 1'b0;
        end else begin
            o_timeout <= 1'b0;
            if ((state != IDLE) && !own_cyc) begin
                // Owner released: hand straight over if the other master waits.
                last_b      <= o_owner[1];
                outstanding <= '0;
                timer       <= '0;
                if (other_cyc) begin
                    state   <= o_owner[1] ? OWN_A : OWN_B;
                    o_owner <= o_owner[1] ? 2'd1 : 2'd2;
                end else begin
                    state   <= IDLE;
                    o_owner <= 2'd0;
                end
            end else begin
                case (state)
                    IDLE: begin
                        outstanding <= '0;
                        timer       <= '0;
                        if (a_cyc && (!b_cyc || last_b)) begin
                            state   <= OWN_A;
                            o_owner <= 2'd1;
                        end else if (b_cyc) begin
                            state   <= OWN_B;
                            o_owner <= 2'd2;
                        end
                    end
                    OWN_A, OWN_B: begin
                        if (fire) begin
                            state       <= ABORT;
                            o_timeout   <= 1'b1;
                            outstanding <= '0;
                            timer       <= '0;
                        end else begin
                            if (accept && !resp) begin
                                outstanding <= outstanding + OUT_W'(1);
                            end else if (resp && !accept) begin
                                outstanding <= outstanding - OUT_W'(1);
                            end
                            timer <= (s_ack | s_err | accept | ~have_out) ? '0 : timer_inc;
                        end
                    end
                    ABORT: begin
                        outstanding <= '0;
                        timer       <= '0;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_wb_arbiter2.sv
module tb_wb_arbiter2;

    localparam int MAXO = 4;
    localparam int TO   = 16;
    localparam int CW   = 5;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        a_cyc, a_stb, a_we;
    logic [29:0] a_addr;
    logic [31:0] a_mosi;
    logic [3:0]  a_sel;
    logic        a_ack, a_stall, a_err;
    logic [31:0] a_miso;
    logic        b_cyc, b_stb, b_we;
    logic [29:0] b_addr;
    logic [31:0] b_mosi;
    logic [3:0]  b_sel;
    logic        b_ack, b_stall, b_err;
    logic [31:0] b_miso;
    logic        s_cyc, s_stb, s_we;
    logic [29:0] s_addr;
    logic [31:0] s_mosi;
    logic [3:0]  s_sel;
    logic        s_ack, s_stall, s_err;
    logic [31:0] s_miso;
    logic [1:0]  o_owner;
    logic        o_timeout;

    wb_arbiter2 #(
        .MAX_OUTSTANDING(MAXO),
        .TIMEOUT_CYCLES (TO),
        .CNT_W          (CW)
    ) dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .a_cyc(a_cyc), .a_stb(a_stb), .a_we(a_we), .a_addr(a_addr), .a_mosi(a_mosi), .a_sel(a_sel),
        .a_ack(a_ack), .a_stall(a_stall), .a_err(a_err), .a_miso(a_miso),
        .b_cyc(b_cyc), .b_stb(b_stb), .b_we(b_we), .b_addr(b_addr), .b_mosi(b_mosi), .b_sel(b_sel),
        .b_ack(b_ack), .b_stall(b_stall), .b_err(b_err), .b_miso(b_miso),
        .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_addr(s_addr), .s_mosi(s_mosi), .s_sel(s_sel),
        .s_ack(s_ack), .s_stall(s_stall), .s_err(s_err), .s_miso(s_miso),
        .o_owner(o_owner), .o_timeout(o_timeout)
    );

    always #5 i_clk = ~i_clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: who owns the bus, how many requests are pending, and
    // how many consecutive silent cycles have passed with requests pending.
    int m_owner, m_last, m_out, m_quiet;
    bit m_abort, m_pulse;

    task automatic check_val(string tag, logic [63:0] got, logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic req_cyc(int m);
        return (m == 1) ? a_cyc : b_cyc;
    endfunction
    function automatic logic req_stb(int m);
        return (m == 1) ? a_stb : b_stb;
    endfunction
    function automatic logic [39:0] req_bus(int m, bit lim);
        if (m == 1) return {a_cyc, a_stb & ~lim, a_we, a_sel, a_addr};
        else        return {b_cyc, b_stb & ~lim, b_we, b_sel, b_addr};
    endfunction
    function automatic logic [31:0] req_mosi(int m);
        return (m == 1) ? a_mosi : b_mosi;
    endfunction

    // {ack, stall, err} the given master must see this cycle.
    function automatic logic [2:0] exp_resp(int m, bit g, bit lim);
        bit   mine;
        logic ack, stall, err;
        mine  = g && (m_owner == m);
        ack   = mine && s_ack && (m_out > 0);
        stall = !mine || s_stall || lim;
        err   = (mine && s_err && (m_out > 0)) || (m_abort && (m_owner == m) && m_pulse);
        return {ack, stall, err};
    endfunction

    task automatic model_reset();
        m_owner = 0; m_last = 2; m_out = 0; m_quiet = 0;
        m_abort = 0; m_pulse = 0;
    endtask

    task automatic idle_inputs();
        a_cyc = 0; a_stb = 0; a_we = 0; a_addr = '0; a_mosi = '0; a_sel = '0;
        b_cyc = 0; b_stb = 0; b_we = 0; b_addr = '0; b_mosi = '0; b_sel = '0;
        s_ack = 0; s_stall = 0; s_err = 0; s_miso = '0;
    endtask

    task automatic sample();
        bit          g, lim;
        logic [39:0] e_req;
        logic [31:0] e_mosi, e_am, e_bm;
        #1;
        g      = (m_owner != 0) && !m_abort;
        lim    = (m_out == MAXO);
        e_req  = g ? req_bus(m_owner, lim) : '0;
        e_mosi = g ? req_mosi(m_owner) : '0;
        e_am   = (g && m_owner == 1) ? s_miso : '0;
        e_bm   = (g && m_owner == 2) ? s_miso : '0;
        check_val("s_req",  64'({s_cyc, s_stb, s_we, s_sel, s_addr}), 64'(e_req));
        check_val("s_mosi", 64'(s_mosi), 64'(e_mosi));
        check_val("a_resp", 64'({a_ack, a_stall, a_err}), 64'(exp_resp(1, g, lim)));
        check_val("b_resp", 64'({b_ack, b_stall, b_err}), 64'(exp_resp(2, g, lim)));
        check_val("a_miso", 64'(a_miso), 64'(e_am));
        check_val("b_miso", 64'(b_miso), 64'(e_bm));
        check_val("owner",  64'({o_owner, o_timeout}), 64'({2'(m_owner), m_pulse}));
    endtask

    task automatic advance();
        bit lim, acc, resp, quiet;
        int other;
        lim = (m_out == MAXO);
        if (m_owner == 0) begin
            m_pulse = 0; m_out = 0; m_quiet = 0;
            if (a_cyc && b_cyc) m_owner = (m_last == 1) ? 2 : 1;
            else if (a_cyc)     m_owner = 1;
            else if (b_cyc)     m_owner = 2;
        end else if (!req_cyc(m_owner)) begin
            other   = 3 - m_owner;
            m_last  = m_owner;
            m_owner = req_cyc(other) ? other : 0;
            m_abort = 0; m_pulse = 0; m_out = 0; m_quiet = 0;
        end else if (m_abort) begin
            m_pulse = 0;
        end else begin
            acc   = req_stb(m_owner) && !lim && !s_stall;
            resp  = (s_ack || s_err) && (m_out > 0);
            quiet = (m_out > 0) && !acc && !s_ack && !s_err;
            m_out = m_out + int'(acc) - int'(resp);
            m_pulse = 0;
            if (quiet) begin
                m_quiet++;
                if (m_quiet == TO - 1) begin
                    m_abort = 1; m_pulse = 1; m_out = 0; m_quiet = 0;
                end
            end else begin
                m_quiet = 0;
            end
        end
        @(posedge i_clk);
        #1;
    endtask

    task automatic step();
        sample();
        advance();
    endtask

    initial begin
        int remaining, acc_cnt, acc_at;
        bit dead;

        idle_inputs();
        i_reset = 1'b1;
        #3;
        check_val("rst_s_cyc",  64'({s_cyc, s_stb}), 64'(0));
        check_val("rst_a_resp", 64'({a_ack, a_stall, a_err}), 64'(3'b010));
        check_val("rst_b_resp", 64'({b_ack, b_stall, b_err}), 64'(3'b010));
        check_val("rst_miso",   64'({a_miso, b_miso}), 64'(0));
        check_val("rst_owner",  64'({o_owner, o_timeout}), 64'(0));
        @(posedge i_clk);
        #1;
        i_reset = 1'b0;
        model_reset();

        // Both masters request together right after reset: A first, then B.
        for (int c = 0; c <= 6; c++) begin
            a_cyc = (c < 5);
            b_cyc = 1'b1;
            sample();
            if (c <= 5) begin
                check_val("t2_b_stall", 64'(b_stall), 64'(1));
                check_val("t2_b_ack",   64'(b_ack),   64'(0));
            end
            if (c >= 1 && c <= 5) check_val("t2_owner_a", 64'(o_owner), 64'(1));
            if (c == 6)           check_val("t2_owner_b", 64'(o_owner), 64'(2));
            advance();
        end
        idle_inputs(); step(); step();

        // Single A read from IDLE.
        a_cyc = 1; a_stb = 1; a_addr = 30'h10;
        sample();
        check_val("t1_stall_c0", 64'(a_stall), 64'(1));
        advance();
        sample();
        check_val("t1_s_stb",  64'(s_stb),   64'(1));
        check_val("t1_s_addr", 64'(s_addr),  64'(30'h10));
        check_val("t1_owner",  64'(o_owner), 64'(1));
        advance();
        a_stb = 0; s_ack = 1; s_miso = 32'hDEADBEEF;
        sample();
        check_val("t1_ack",  64'(a_ack),  64'(1));
        check_val("t1_miso", 64'(a_miso), 64'(32'hDEADBEEF));
        advance();
        idle_inputs(); step(); step();

        // Pipelining limit: six stbs, acks held back.
        remaining = 6; acc_cnt = 0;
        a_cyc = 1; a_we = 1;
        for (int c = 0; c < 16; c++) begin
            a_stb  = (remaining > 0);
            a_addr = 30'($urandom);
            a_mosi = $urandom;
            s_ack  = (c == 8) || (c >= 10);
            sample();
            if (s_stb && !s_stall) acc_cnt++;
            if (c >= 5 && c <= 8) begin
                check_val("t3_stall_at_limit", 64'(a_stall), 64'(1));
                check_val("t3_stb_gated",      64'(s_stb),   64'(0));
            end
            if (c == 8) begin
                check_val("t3_accepted_at_limit", 64'(acc_cnt), 64'(4));
                check_val("t3_ack", 64'(a_ack), 64'(1));
            end
            if (c == 9) begin
                check_val("t3_stb_after_ack",   64'(s_stb),   64'(1));
                check_val("t3_stall_after_ack", 64'(a_stall), 64'(0));
            end
            if (a_stb && !a_stall) remaining--;
            advance();
        end
        check_val("t3_total", 64'(acc_cnt), 64'(6));
        idle_inputs(); step(); step();

        // Timeout: one accepted request, slave never answers; B waits.
        acc_at = -1;
        a_cyc = 1; a_addr = 30'h3f0;
        for (int c = 0; c < 24; c++) begin
            a_stb = (acc_at < 0);
            b_cyc = (c >= 10);
            if (c >= 21) a_cyc = 0;
            sample();
            if (acc_at >= 0 && c > acc_at && c <= acc_at + 17)
                check_val("t4_err_pulse", 64'({a_err, o_timeout}),
                          (c == acc_at + 16) ? 64'(3) : 64'(0));
            if (acc_at >= 0 && c >= acc_at + 16 && c < 21) begin
                check_val("t4_s_cyc_low", 64'(s_cyc),   64'(0));
                check_val("t4_a_stall",   64'(a_stall), 64'(1));
            end
            if (c >= 10 && c < 22) check_val("t4_b_wait",  64'(b_stall), 64'(1));
            if (c == 22)           check_val("t4_b_owner", 64'(o_owner), 64'(2));
            if (a_stb && !a_stall && acc_at < 0) acc_at = c;
            advance();
        end
        check_val("t4_accept_cycle", 64'(acc_at), 64'(1));
        idle_inputs(); step(); step();

        // Slave error, then a stray ack with nothing pending.
        a_cyc = 1; a_stb = 1; a_addr = 30'h55;
        step();
        step();
        a_stb = 0; s_err = 1;
        sample();
        check_val("t5_err",        64'(a_err), 64'(1));
        check_val("t5_err_no_ack", 64'(a_ack), 64'(0));
        advance();
        s_err = 0;
        sample();
        check_val("t5_err_once", 64'(a_err), 64'(0));
        advance();
        s_ack = 1;
        sample();
        check_val("t5_stray_ack", 64'({a_ack, b_ack}), 64'(0));
        check_val("t5_owner",     64'(o_owner), 64'(1));
        advance();
        idle_inputs(); step();
        s_ack = 1;
        sample();
        check_val("t5_stray_idle", 64'({a_ack, b_ack}), 64'(0));
        advance();
        idle_inputs(); step();

        // Asynchronous reset with three requests pending.
        a_cyc = 1;
        for (int c = 0; c < 4; c++) begin
            a_stb = 1;
            step();
        end
        a_stb = 0;
        sample();
        #1;
        i_reset = 1'b1;
        #1;
        check_val("t6_s_cyc",  64'(s_cyc),   64'(0));
        check_val("t6_owner",  64'(o_owner), 64'(0));
        check_val("t6_a_stall", 64'(a_stall), 64'(1));
        idle_inputs();
        @(posedge i_clk);
        #1;
        i_reset = 1'b0;
        model_reset();
        a_cyc = 1; a_stb = 1; a_addr = 30'h20;
        step();
        step();
        a_stb = 0; s_ack = 1; s_miso = 32'h12345678;
        sample();
        check_val("t6_fresh_ack",  64'(a_ack),  64'(1));
        check_val("t6_fresh_miso", 64'(a_miso), 64'(32'h12345678));
        advance();
        idle_inputs(); step(); step();

        // Randomized traffic against the model, with silent-slave stretches.
        dead = 0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(63) == 0) dead = !dead;
            a_cyc   = a_cyc ? ($urandom_range(15) != 0) : ($urandom_range(3) == 0);
            b_cyc   = b_cyc ? ($urandom_range(15) != 0) : ($urandom_range(3) == 0);
            a_stb   = ($urandom_range(1) == 1);
            b_stb   = ($urandom_range(1) == 1);
            a_we    = ($urandom_range(1) == 1);
            b_we    = ($urandom_range(1) == 1);
            a_addr  = 30'($urandom);
            b_addr  = 30'($urandom);
            a_mosi  = $urandom;
            b_mosi  = $urandom;
            a_sel   = 4'($urandom);
            b_sel   = 4'($urandom);
            s_stall = ($urandom_range(3) == 0);
            s_ack   = !dead && ($urandom_range(2) == 0);
            s_err   = !dead && ($urandom_range(31) == 0);
            s_miso  = $urandom;
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
